alu_operand_stage: RTL

//  ID/EX pipeline stage directly upstream of the 32-bit ALU (A, B, F[3:0], shamt).

---
 rtl/alu_operand_stage_if.sv | 57 +++++
 rtl/alu_operand_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// ID/EX operand-stage bus: decode-side op, MEM/WB forward buses, and
// the registered op presented to the ALU.
interface alu_operand_stage_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5
);
    // decode side
    logic               id_valid;
    logic               id_ready;
    logic [REGBITS-1:0] id_rs;
    logic [REGBITS-1:0] id_rt;
    logic [WIDTH-1:0]   id_rs_val;
    logic [WIDTH-1:0]   id_rt_val;
    logic [WIDTH-1:0]   id_imm;
    logic               id_alusrc;
    logic [3:0]         id_aluctl;
    logic [4:0]         id_shamt;
    logic [REGBITS-1:0] id_rd;
    logic               id_regwrite;
    logic               flush;

    // write-back forward buses
    logic               mem_we;
    logic [REGBITS-1:0] mem_rd;
    logic [WIDTH-1:0]   mem_data;
    logic               wb_we;
    logic [REGBITS-1:0] wb_rd;
    logic [WIDTH-1:0]   wb_data;

    // ALU side
    logic               ex_valid;
    logic               ex_ready;
    logic [WIDTH-1:0]   ex_a;
    logic [WIDTH-1:0]   ex_b;
    logic [3:0]         ex_f;
    logic [4:0]         ex_shamt;
    logic [REGBITS-1:0] ex_rd;
    logic               ex_regwrite;

    // environment (decode, forward sources, ALU)
    modport master (
        output id_valid, id_rs, id_rt, id_rs_val, id_rt_val, id_imm,
               id_alusrc, id_aluctl, id_shamt, id_rd, id_regwrite, flush,
               mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, ex_ready,
        input  id_ready, ex_valid, ex_a, ex_b, ex_f, ex_shamt, ex_rd,
               ex_regwrite
    );

    // the operand stage itself
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_val, id_rt_val, id_imm,
               id_alusrc, id_aluctl, id_shamt, id_rd, id_regwrite, flush,
               mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, ex_ready,
        output id_ready, ex_valid, ex_a, ex_b, ex_f, ex_shamt, ex_rd,
               ex_regwrite
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: captures one decoded ALU op per cycle, resolves
// RAW hazards by forwarding from MEM/WB, and refreshes held operands
// from the forward buses while the ALU side stalls.
module alu_operand_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5,
    parameter bit          FWD_EN  = 1'b1
) (
    input logic              clk,
    input logic              reset,
    alu_operand_stage_if.slave bus
);

    logic               ex_valid_q;
    logic [WIDTH-1:0]   ex_a_q;
    logic [WIDTH-1:0]   ex_b_q;
    logic [3:0]         ex_f_q;
    logic [4:0]         ex_shamt_q;
    logic [REGBITS-1:0] ex_rd_q;
    logic               ex_regwrite_q;

    // source register numbers and B select of the held op, for snooping
    logic [REGBITS-1:0] rs_q;
    logic [REGBITS-1:0] rt_q;
    logic               alusrc_q;

    logic               id_ready_c;
    logic               capture;
    logic               hold;
    logic               drain;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    logic [WIDTH-1:0]   snoop_a;
    logic [WIDTH-1:0]   snoop_b;

    // r0 always reads zero; MEM beats WB on the same register
    function automatic logic [WIDTH-1:0] fwd(
        input logic [REGBITS-1:0] r,
        input logic [WIDTH-1:0]   v,
        input logic               m_we,
        input logic [REGBITS-1:0] m_rd,
        input logic [WIDTH-1:0]   m_data,
        input logic               w_we,
        input logic [REGBITS-1:0] w_rd,
        input logic [WIDTH-1:0]   w_data
    );
        logic [WIDTH-1:0] res;
        res = v;
        if (r == '0) begin
            res = '0;
        end else if (FWD_EN) begin
            if (m_we && (m_rd == r)) begin
                res = m_data;
            end else if (w_we && (w_rd == r)) begin
                res = w_data;
            end
        end
        return res;
    endfunction

    // handshake qualification and forwarded operand selection
    always_comb begin
        id_ready_c = !ex_valid_q || bus.ex_ready;
        capture    = bus.id_valid && id_ready_c && !bus.flush;
        hold       = ex_valid_q && !bus.ex_ready && !bus.flush;
        drain      = ex_valid_q && bus.ex_ready && !capture && !bus.flush;

        cap_a = fwd(bus.id_rs, bus.id_rs_val, bus.mem_we, bus.mem_rd,
                    bus.mem_data, bus.wb_we, bus.wb_rd, bus.wb_data);
        cap_b = bus.id_alusrc ? bus.id_imm
              : fwd(bus.id_rt, bus.id_rt_val, bus.mem_we, bus.mem_rd,
                    bus.mem_data, bus.wb_we, bus.wb_rd, bus.wb_data);

        // a held register operand follows any later write to its source
        snoop_a = fwd(rs_q, ex_a_q, bus.mem_we, bus.mem_rd, bus.mem_data,
                      bus.wb_we, bus.wb_rd, bus.wb_data);
        snoop_b = alusrc_q ? ex_b_q
                : fwd(rt_q, ex_b_q, bus.mem_we, bus.mem_rd, bus.mem_data,
                      bus.wb_we, bus.wb_rd, bus.wb_data);
    end

    // pipeline register: flush > capture > hold-with-snoop > drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_f_q        <= '0;
            ex_shamt_q    <= '0;
            ex_rd_q       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            alusrc_q      <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
        end else if (capture) begin
            ex_valid_q    <= 1'b1;
            ex_regwrite_q <= bus.id_regwrite;
            ex_a_q        <= cap_a;
            ex_b_q        <= cap_b;
            ex_f_q        <= bus.id_aluctl;
            ex_shamt_q    <= bus.id_shamt;
            ex_rd_q       <= bus.id_rd;
            rs_q          <= bus.id_rs;
            rt_q          <= bus.id_rt;
            alusrc_q      <= bus.id_alusrc;
        end else if (hold) begin
            ex_a_q        <= snoop_a;
            ex_b_q        <= snoop_b;
        end else if (drain) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
        end
    end

    assign bus.id_ready    = id_ready_c;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_a        = ex_a_q;
    assign bus.ex_b        = ex_b_q;
    assign bus.ex_f        = ex_f_q;
    assign bus.ex_shamt    = ex_shamt_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_regwrite = ex_regwrite_q;

endmodule
